water_tank_emulator: RTL
========================

Name: water_tank_emulator

Overview:
- Plant-side model of the irrigation tank: the other end of the controller's sensor/actuator interface.
- Consumes the actuator commands `water_supply_valvule`, `splinker_bomb` and `dripper_valvule`.
- Integrates tank level over time and drives the three thermometer-coded level sensors back to the controller.
- Used for closed-loop simulation and FPGA board demo. Also provides sensor fault injection to exercise the controller's conflict/alarm path.

Parameters:
- LEVEL_WIDTH, 8, width of level register.
- CAPACITY, 200, maximum level (full tank); must be < 2^LEVEL_WIDTH.
- INITIAL_LEVEL, 120, level loaded on reset.
- LOW_THRESHOLD, 40, level at or above which `low_water_level`=1.
- MID_THRESHOLD, 100, level at or above which `mid_water_level`=1.
- HIGH_THRESHOLD, 160, level at or above which `high_water_level`=1.
- FILL_RATE, 4, units added per tick while supply valve open.
- SPRINKLER_DRAIN, 3, units removed per tick while sprinkler pump on.
- DRIPPER_DRAIN, 1, units removed per tick while dripper valve open.
- TICK_DIVISOR, 1000, clock cycles per level update (>=2).

Ports:
- `clock`  input  1  system clock, rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `water_supply_valvule`  input  1  supply valve open.
- `splinker_bomb`  input  1  sprinkler pump on.
- `dripper_valvule`  input  1  dripper valve open.
- `fault_enable`  input  1  override sensor outputs with `fault_pattern`.
- `fault_pattern`  input  3  {high,mid,low} forced sensor values.
- `low_water_level`  output  1  low sensor (1 = water at/above low mark).
- `mid_water_level`  output  1  mid sensor.
- `high_water_level`  output  1  high sensor.
- `level`  output  LEVEL_WIDTH  current tank level.
- `tank_state`  output  2  0 STABLE, 1 FILLING, 2 DRAINING, 3 FULL.
- `overflow`  output  1  sticky: fill attempted with tank full.
- `dry_run`  output  1  sticky: drain attempted with tank empty.

Behaviour:
- One clock domain. Reset is synchronous, active-high, and has priority over all other activity.
- Reset values:
  - `level` = INITIAL_LEVEL; prescaler = 0; `overflow` = 0; `dry_run` = 0.
  - Sensors = thermometer code of INITIAL_LEVEL (defaults: low=1, mid=1, high=0).
  - `tank_state` = STABLE, or FULL if INITIAL_LEVEL == CAPACITY.
- Prescaler:
  - Counts 0..TICK_DIVISOR-1 and wraps to 0.
  - `tick` is internal, high in the cycle where count == TICK_DIVISOR-1.
  - First tick after reset is in cycle TICK_DIVISOR-1.
- Level update, only on tick cycles, using inputs sampled in that cycle:
  - net = FILL_RATE*valve − SPRINKLER_DRAIN*pump − DRIPPER_DRAIN*dripper.
  - Computed signed in LEVEL_WIDTH+2 bits.
  - Next level = clamp(level + net, 0, CAPACITY); saturating, never wraps.
  - New level is visible on the clock edge that ends the tick cycle.
- Sensors are registered and updated on the same edge as `level`, from the next level:
  - low = next ≥ LOW_THRESHOLD; mid = next ≥ MID_THRESHOLD; high = next ≥ HIGH_THRESHOLD.
  - Between ticks, sensors hold.
- Fault injection:
  - While `fault_enable`=1, the sensor registers load `fault_pattern` every cycle; latency 1 cycle, independent of tick.
  - `level` keeps integrating while faulted.
  - When `fault_enable` drops, sensors return to the true thermometer code of `level` on the next edge.
- tank_state FSM, evaluated on tick cycles only:
  - next level == CAPACITY → FULL.
  - else net > 0 → FILLING; net < 0 → DRAINING; net == 0 → STABLE.
  - Any state may go to any state.
  - FULL is left only when the next level < CAPACITY.
- Sticky flags, set on tick cycles, cleared only by reset:
  - `overflow` sets when level == CAPACITY and valve=1.
  - `dry_run` sets when level == 0 and (pump or dripper)=1.
- Simultaneous fill and drain: net arithmetic applies; equal rates give STABLE with no level change.
- Reset asserted mid-tick: prescaler restarts at 0 and any pending update is discarded.
- Input changes between ticks have no effect on `level` or `tank_state`.

Test Plan (TICK_DIVISOR=4, other defaults):
- Reset, all inputs 0, run 20 cycles -> level=120, sensors {h,m,l}=011, tank_state=STABLE, flags 0.
- valve=1 from reset -> level +4 every 4 cycles; level=160 and high=1 at the edge ending cycle 39 (10th tick); tank_state=FILLING.
- valve=1 held until level=200 -> tank_state=FULL. The next tick sets `overflow`=1. Level stays 200.
- Pump and dripper on, valve off, from 120 -> −4/tick; mid drops at 96 (tick 6); low drops at 36 (tick 21); level clamps at 0; the next tick sets `dry_run`=1; tank_state=DRAINING.
- valve=1 with dripper=1 and pump=1 -> net 0, level constant, tank_state=STABLE; then drop pump -> +3/tick.
- `fault_enable`=1 with pattern 100 at cycle 10 -> sensors=100 at cycle 11 while level still updates. Deassert -> sensors=011 next cycle. Assert `reset` mid-tick -> all reset values on the next edge.

Source files
------------

// File: rtl/water_tank_emulator.sv
// Plant model of the irrigation tank: integrates level from actuator commands once per
// prescaler tick and returns thermometer-coded level sensors, with sensor fault injection.
//
// state    | meaning
// ---------+---------------------------------------------------------
// STABLE   | net flow was zero on the last tick
// FILLING  | net flow was positive on the last tick, tank below full
// DRAINING | net flow was negative on the last tick
// FULL     | level sits at CAPACITY
module water_tank_emulator #(
   parameter int LEVEL_WIDTH     = 8,
   parameter int CAPACITY        = 200,
   parameter int INITIAL_LEVEL   = 120,
   parameter int LOW_THRESHOLD   = 40,
   parameter int MID_THRESHOLD   = 100,
   parameter int HIGH_THRESHOLD  = 160,
   parameter int FILL_RATE       = 4,
   parameter int SPRINKLER_DRAIN = 3,
   parameter int DRIPPER_DRAIN   = 1,
   parameter int TICK_DIVISOR    = 1000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   water_supply_valvule,
   input  logic                   splinker_bomb,
   input  logic                   dripper_valvule,
   input  logic                   fault_enable,
   input  logic [2:0]             fault_pattern,
   output logic                   low_water_level,
   output logic                   mid_water_level,
   output logic                   high_water_level,
   output logic [LEVEL_WIDTH-1:0] level,
   output logic [1:0]             tank_state,
   output logic                   overflow,
   output logic                   dry_run
);

   localparam int NW = LEVEL_WIDTH + 2;
   localparam int CW = (TICK_DIVISOR > 2) ? $clog2(TICK_DIVISOR) : 1;

   localparam logic [CW-1:0]          TC_L   = CW'(TICK_DIVISOR - 1);
   localparam logic [LEVEL_WIDTH-1:0] CAP_L  = LEVEL_WIDTH'(CAPACITY);
   localparam logic [LEVEL_WIDTH-1:0] INIT_L = LEVEL_WIDTH'(INITIAL_LEVEL);
   localparam logic [LEVEL_WIDTH-1:0] LOW_L  = LEVEL_WIDTH'(LOW_THRESHOLD);
   localparam logic [LEVEL_WIDTH-1:0] MID_L  = LEVEL_WIDTH'(MID_THRESHOLD);
   localparam logic [LEVEL_WIDTH-1:0] HIGH_L = LEVEL_WIDTH'(HIGH_THRESHOLD);
   localparam logic signed [NW-1:0]   FILL_S = NW'(FILL_RATE);
   localparam logic signed [NW-1:0]   SPR_S  = NW'(SPRINKLER_DRAIN);
   localparam logic signed [NW-1:0]   DRIP_S = NW'(DRIPPER_DRAIN);
   localparam logic signed [NW-1:0]   CAP_S  = NW'(CAPACITY);

   typedef enum logic [1:0] {
      STABLE   = 2'd0,
      FILLING  = 2'd1,
      DRAINING = 2'd2,
      FULL     = 2'd3
   } state_t;

   localparam state_t RESET_STATE = (INITIAL_LEVEL == CAPACITY) ? FULL : STABLE;

   function automatic logic [2:0] therm(input logic [LEVEL_WIDTH-1:0] l);
      therm = {l >= HIGH_L, l >= MID_L, l >= LOW_L};
   endfunction

   logic [CW-1:0]          count;
   logic                   tick;
   logic signed [NW-1:0]   net;
   logic signed [NW-1:0]   sum;
   logic [LEVEL_WIDTH-1:0] level_next;
   logic [2:0]             sensors;
   state_t                 state_q;
   state_t                 state_d;

   assign tick = (count == TC_L);

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   always_comb begin
      net = '0;
      if (water_supply_valvule) net = net + FILL_S;
      if (splinker_bomb)        net = net - SPR_S;
      if (dripper_valvule)      net = net - DRIP_S;
   end

   // Extra two bits keep level+net signed and free of wrap before the clamp.
   always_comb begin
      sum        = $signed({2'b00, level}) + net;
      level_next = sum[LEVEL_WIDTH-1:0];
      if (sum < 0) begin
         level_next = '0;
      end else if (sum > CAP_S) begin
         level_next = CAP_L;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         level    <= INIT_L;
         overflow <= 1'b0;
         dry_run  <= 1'b0;
      end else if (tick) begin
         level <= level_next;
         if (level == CAP_L && water_supply_valvule) overflow <= 1'b1;
         if (level == '0 && (splinker_bomb || dripper_valvule)) dry_run <= 1'b1;
      end
   end

   // Between ticks the level is constant, so reloading its code doubles as hold and fault release.
   always_ff @(posedge clock) begin
      if (reset) begin
         sensors <= therm(INIT_L);
      end else if (fault_enable) begin
         sensors <= fault_pattern;
      end else if (tick) begin
         sensors <= therm(level_next);
      end else begin
         sensors <= therm(level);
      end
   end

   assign low_water_level  = sensors[0];
   assign mid_water_level  = sensors[1];
   assign high_water_level = sensors[2];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (tick) begin
         if (level_next == CAP_L) begin
            state_d = FULL;
         end else if (net > 0) begin
            state_d = FILLING;
         end else if (net < 0) begin
            state_d = DRAINING;
         end else begin
            state_d = STABLE;
         end
      end
   end

   assign tank_state = state_q;

endmodule
